// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg -- shared definitions for the timer scheduler.
//   state_t        : scheduler FSM states (IDLE, RUN, DONE)
//   NREQ           : number of requesters (only 2 supported)
//   PRESCALE_W     : width of the optional tick prescaler
//   PRESCALE_TERM  : prescaler value that produces a counter tick
package timer_sched_pkg;

  localparam int NREQ = 2;

  localparam int PRESCALE_W = 4;
  localparam logic [PRESCALE_W-1:0] PRESCALE_TERM = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sched_cnt.sv
// sched_cnt -- W-bit shared interval counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : increment by one this cycle
//   tc         : terminal count to compare against
//   cnt        : current count
//   at_tc      : cnt equals tc
module sched_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic [W-1:0] cnt,
  output logic         at_tc
);

  assign at_tc = (cnt == tc);

  // The owner never enables the counter while at_tc is high, so it
  // cannot wrap even when tc is all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched -- two-requester round-robin scheduler for one shared
// interval timer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : level request per requester, held until done/withdrawn
//   len0, len1 : interval length per requester, sampled at grant
//   gnt[1:0]   : one-hot owner of the shared counter
//   busy       : high in RUN or DONE
//   done[1:0]  : one-cycle pulse on the owner's bit at completion
//   abort      : one-cycle pulse after the owner withdrew mid-interval
//   cnt        : shared counter value
// Build option: define TIMER_SCHED_PRESCALE_EN to make the counter
// tick once every 16 clocks while running instead of every clock.
module timer_sched #(
  parameter int W    = 8,
  parameter int NREQ = timer_sched_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    len0,
  input  logic [W-1:0]    len1,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic            abort,
  output logic [W-1:0]    cnt
);

  import timer_sched_pkg::*;

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [W-1:0]    tc;
  logic [W-1:0]    tc_nxt;
  logic            rr;
  logic            rr_nxt;
  logic            abort_nxt;
  logic            owner;
  logic            owner_req;
  logic            win;
  logic            tick;
  logic            at_tc;
  logic            cnt_clr;
  logic            cnt_en;

  // Only two requesters exist, so the owner index is simply gnt[1].
  assign owner     = gnt[1];
  assign owner_req = |(req & gnt);

  // The pointer only breaks ties; a lone requester always wins.
  assign win = (req == 2'b11) ? rr : req[1];

`ifdef TIMER_SCHED_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre;

  // Prescaler is held at zero outside RUN, so every interval starts
  // with a full 16-clock tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (state == ST_RUN) begin
      pre <= pre + 1'b1;
    end else begin
      pre <= '0;
    end
  end

  assign tick = (pre == PRESCALE_TERM);
`else
  assign tick = 1'b1;
`endif

  sched_cnt #(.W(W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc),
    .cnt   (cnt),
    .at_tc (at_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      tc    <= '0;
      rr    <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      tc    <= tc_nxt;
      rr    <= rr_nxt;
      abort <= abort_nxt;
    end
  end

  // Withdrawal of the owner's request takes precedence over the
  // terminal tick, so a dropped request never produces a done pulse.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    tc_nxt    = tc;
    rr_nxt    = rr;
    abort_nxt = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (|req) begin
          state_nxt = ST_RUN;
          gnt_nxt   = {win, ~win};
          tc_nxt    = win ? len1 : len0;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          rr_nxt    = ~owner;
          abort_nxt = 1'b1;
          cnt_clr   = 1'b1;
        end else if (tick) begin
          if (at_tc) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        rr_nxt    = ~owner;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE) ? gnt : '0;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched -- self-checking bench for timer_sched.
// The reference model tracks the current owner, its sampled length and
// the clocks elapsed since grant; expected outputs follow from that
// with plain arithmetic. Honours TIMER_SCHED_PRESCALE_EN.
module tb_timer_sched;

  localparam int W = 8;
`ifdef TIMER_SCHED_PRESCALE_EN
  localparam int PRE = 16;
`else
  localparam int PRE = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic [1:0]   gnt;
  logic         busy;
  logic [1:0]   done;
  logic         abort;
  logic [W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_owner;
  int  m_len;
  int  m_elapsed;
  bit  m_in_done;
  int  m_rr;

  logic [1:0]   e_gnt;
  logic [1:0]   e_done;
  logic         e_abort;
  logic         e_busy;
  logic [W-1:0] e_cnt;

  timer_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .abort (abort),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner   = -1;
    m_len     = 0;
    m_elapsed = 0;
    m_in_done = 1'b0;
    m_rr      = 0;
    e_gnt     = 2'b00;
    e_done    = 2'b00;
    e_abort   = 1'b0;
    e_busy    = 1'b0;
    e_cnt     = '0;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  function automatic void model_step();
    int w;
    e_done  = 2'b00;
    e_abort = 1'b0;
    if (m_owner < 0) begin
      if (req != 2'b00) begin
        w = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
        m_owner   = w;
        m_len     = (w == 1) ? int'(len1) : int'(len0);
        m_elapsed = 0;
        m_in_done = 1'b0;
        e_gnt     = (w == 1) ? 2'b10 : 2'b01;
        e_busy    = 1'b1;
        e_cnt     = '0;
      end else begin
        e_gnt  = 2'b00;
        e_busy = 1'b0;
        e_cnt  = '0;
      end
    end else if (m_in_done) begin
      m_rr      = 1 - m_owner;
      m_owner   = -1;
      m_in_done = 1'b0;
      e_gnt     = 2'b00;
      e_busy    = 1'b0;
      e_cnt     = '0;
    end else if (!req[m_owner]) begin
      m_rr    = 1 - m_owner;
      m_owner = -1;
      e_abort = 1'b1;
      e_gnt   = 2'b00;
      e_busy  = 1'b0;
      e_cnt   = '0;
    end else if (m_elapsed + 1 == PRE * (m_len + 1)) begin
      m_in_done = 1'b1;
      e_done    = (m_owner == 1) ? 2'b10 : 2'b01;
      e_cnt     = W'(m_len);
    end else begin
      m_elapsed++;
      e_cnt = W'(m_elapsed / PRE);
    end
  endfunction

  function automatic string diff_str();
    return $sformatf("gnt=%b req'd %b done=%b req'd %b abort=%b req'd %b busy=%b req'd %b cnt=%0d req'd %0d",
                     gnt, e_gnt, done, e_done, abort, e_abort, busy, e_busy, cnt, e_cnt);
  endfunction

  task automatic step_clock();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    len0  = '0;
    len1  = '0;
    model_reset();
    #1;
    checks++;
    if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
      errors++;
      $display("[TB] FAIL reset_initial: %s", diff_str());
    end
    req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
      errors++;
      $display("[TB] FAIL reset_held: %s", diff_str());
    end
    @(negedge clk);
    req   = 2'b00;
    rst_n = 1'b1;
    step_clock();
    checks++;
    if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: %s", diff_str());
    end
  endtask

  task automatic test_basic();
    int done_cyc = -1;
    int done_cnt = 0;
    apply_reset();
    req  = 2'b01;
    len0 = W'(5);
    len1 = W'($urandom);
    for (int cyc = 1; cyc <= PRE * 6 + 2; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL basic cyc %0d: %s", cyc, diff_str());
      end
      if (cyc == 1) begin
        checks++;
        if (gnt !== 2'b01) begin
          errors++;
          $display("[TB] FAIL basic_first_gnt: gnt=%b req'd 01", gnt);
        end
      end
      if (done[0] === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
      if (done_cyc > 0) req = 2'b00;
      len0 = W'($urandom);
    end
    checks++;
    if (done_cyc != PRE * 6 + 1) begin
      errors++;
      $display("[TB] FAIL basic_done_cycle: got %0d req'd %0d", done_cyc, PRE * 6 + 1);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL basic_done_count: got %0d req'd 1", done_cnt);
    end
  endtask

  task automatic test_round_robin();
    int done0_cyc = -1;
    int gnt1_cyc  = -1;
    int done1_cyc = -1;
    apply_reset();
    req  = 2'b11;
    len0 = W'(2);
    len1 = W'(3);
    for (int cyc = 1; cyc <= PRE * 7 + 8; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL rr cyc %0d: %s", cyc, diff_str());
      end
      if (cyc == 1) begin
        checks++;
        if (gnt !== 2'b01) begin
          errors++;
          $display("[TB] FAIL rr_first_gnt: gnt=%b req'd 01", gnt);
        end
      end
      if (done[0] === 1'b1 && done0_cyc < 0) done0_cyc = cyc;
      if (gnt === 2'b10 && gnt1_cyc < 0) gnt1_cyc = cyc;
      if (done[1] === 1'b1 && done1_cyc < 0) done1_cyc = cyc;
      @(negedge clk);
      if (done1_cyc > 0) begin
        req = 2'b00;
        if (cyc > done1_cyc) break;
      end
    end
    checks++;
    if (done0_cyc < 0 || gnt1_cyc - done0_cyc != 2) begin
      errors++;
      $display("[TB] FAIL rr_gap: done0 at %0d gnt1 at %0d req'd gap 2", done0_cyc, gnt1_cyc);
    end
    checks++;
    if (gnt1_cyc < 0 || done1_cyc - gnt1_cyc != PRE * 4) begin
      errors++;
      $display("[TB] FAIL rr_second_len: gnt1 at %0d done1 at %0d req'd span %0d", gnt1_cyc, done1_cyc, PRE * 4);
    end
  endtask

  task automatic test_abort();
    int drop_cyc  = -1;
    int abort_cyc = -1;
    int abort_cnt = 0;
    int done0_cnt = 0;
    apply_reset();
    req  = 2'b11;
    len0 = W'(10);
    len1 = W'(3);
    for (int cyc = 1; cyc <= PRE * 5 + 10; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL abort cyc %0d: %s", cyc, diff_str());
      end
      if (abort === 1'b1) begin
        abort_cnt++;
        if (abort_cyc < 0) abort_cyc = cyc;
      end
      if (done[0] === 1'b1) done0_cnt++;
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        checks++;
        if (gnt !== 2'b10) begin
          errors++;
          $display("[TB] FAIL abort_next_gnt: gnt=%b req'd 10", gnt);
        end
        break;
      end
      @(negedge clk);
      if (drop_cyc < 0 && gnt === 2'b01 && cnt === W'(3)) begin
        drop_cyc = cyc;
        req      = 2'b10;
      end
    end
    checks++;
    if (abort_cnt != 1 || abort_cyc != drop_cyc + 1) begin
      errors++;
      $display("[TB] FAIL abort_pulse: count %0d at %0d req'd 1 at %0d", abort_cnt, abort_cyc, drop_cyc + 1);
    end
    checks++;
    if (done0_cnt != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: done0 pulses %0d req'd 0", done0_cnt);
    end
    req = 2'b00;
  endtask

  task automatic test_boundary();
    int done0_cyc = -1;
    int gnt1_cyc  = -1;
    int done1_cyc = -1;
    int max_cnt   = 0;
    int wraps     = 0;
    int prev_cnt  = 0;
    apply_reset();
    req  = 2'b01;
    len0 = W'(0);
    len1 = W'(255);
    for (int cyc = 1; cyc <= PRE * 258 + 10; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL boundary cyc %0d: %s", cyc, diff_str());
      end
      if (done[0] === 1'b1 && done0_cyc < 0) done0_cyc = cyc;
      if (gnt === 2'b10) begin
        if (gnt1_cyc < 0) begin
          gnt1_cyc = cyc;
          prev_cnt = 0;
        end
        if (int'(cnt) < prev_cnt) wraps++;
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        prev_cnt = int'(cnt);
      end
      if (done[1] === 1'b1 && done1_cyc < 0) done1_cyc = cyc;
      @(negedge clk);
      if (done0_cyc > 0 && gnt1_cyc < 0) req = 2'b10;
      if (gnt1_cyc > 0) len1 = W'($urandom);
      len0 = W'($urandom);
      if (done1_cyc > 0) begin
        req = 2'b00;
        if (cyc > done1_cyc) break;
      end
    end
    checks++;
    if (done0_cyc != PRE + 1) begin
      errors++;
      $display("[TB] FAIL boundary_len0_done: at %0d req'd %0d", done0_cyc, PRE + 1);
    end
    checks++;
    if (max_cnt != 255 || wraps != 0) begin
      errors++;
      $display("[TB] FAIL boundary_max_cnt: max %0d wraps %0d req'd 255 and 0", max_cnt, wraps);
    end
    checks++;
    if (gnt1_cyc < 0 || done1_cyc - gnt1_cyc != PRE * 256) begin
      errors++;
      $display("[TB] FAIL boundary_len1_span: gnt %0d done %0d req'd span %0d", gnt1_cyc, done1_cyc, PRE * 256);
    end
  endtask

  task automatic test_reset_mid_run();
    bit reached = 1'b0;
    int pulses  = 0;
    apply_reset();
    req  = 2'b01;
    len0 = W'(20);
    for (int cyc = 1; cyc <= PRE * 5 + 3; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL midrst cyc %0d: %s", cyc, diff_str());
      end
      if (cnt === W'(4)) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("[TB] FAIL midrst_reach_cnt4: cnt=%0d req'd 4", cnt);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
      errors++;
      $display("[TB] FAIL midrst_async: %s", diff_str());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL midrst_after cyc %0d: %s", cyc, diff_str());
      end
      if (abort === 1'b1 || done !== 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL midrst_no_pulse: %0d done/abort pulses req'd 0", pulses);
    end
    req = 2'b00;
  endtask

  task automatic test_random();
    apply_reset();
    len0 = W'($urandom_range(0, 5));
    len1 = W'($urandom_range(0, 5));
    for (int cyc = 1; cyc <= 600; cyc++) begin
      step_clock();
      checks++;
      if ({gnt, done, abort, busy, cnt} !== {e_gnt, e_done, e_abort, e_busy, e_cnt}) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: %s", cyc, diff_str());
      end
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      len0 = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
      len1 = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_boundary();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter W, default 8, width of counter and interval length.
REQ-002 Parameter NREQ, fixed 2, number of requesters; other values not supported.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester level request for one timed interval; held until done or withdrawn.
REQ-006 len0, len1  input  W each  interval length per requester; sampled only at grant.
REQ-007 gnt  output  2  one-hot grant; owner of the shared counter.
REQ-008 busy  output  1  high in RUN or DONE.
REQ-009 done  output  2  one-cycle pulse on owner's bit at interval completion.
REQ-010 abort  output  1  one-cycle pulse when owner withdraws req mid-interval.
REQ-011 cnt  output  W  current shared counter value.

Function
REQ-012 States: IDLE, RUN, DONE; encoding free, one-hot or binary.
REQ-013 IDLE: gnt=0, cnt=0, busy=0; on any req bit set, next cycle enters RUN with gnt set to winner, tc latched from winner's len, cnt=0.
REQ-014 Arbitration round-robin: rr pointer names preferred requester; only one req set -> that one wins regardless of pointer.
REQ-015 Both req set in IDLE -> requester named by rr wins; other waits, no starvation.
REQ-016 RUN: cnt increments by 1 per tick; without prescaler a tick is every clk.
REQ-017 RUN: on tick with cnt==tc -> DONE next cycle; cnt holds at tc; RUN lasts tc+1 ticks.
REQ-018 len=0 -> RUN one tick, then DONE.
REQ-019 len=2^W-1 -> cnt reaches all-ones, no wrap, then DONE.
REQ-020 DONE: exactly one cycle; done[owner]=1, gnt held; rr set to the non-owner; next state IDLE.
REQ-021 Owner's req low during RUN -> next cycle IDLE, abort=1 that cycle, no done pulse, rr set to non-owner, cnt cleared.
REQ-022 Owner's req low in DONE cycle -> DONE completes normally, no abort.
REQ-023 Non-owner req changes during RUN/DONE ignored; len inputs ignored outside grant.
REQ-024 Back-to-back: after DONE, IDLE one cycle minimum before next RUN; grant-to-grant overhead 2 cycles.
REQ-025 gnt, done never have more than one bit set; done and abort never coincide.

Reset
REQ-026 rst_n low asynchronously forces IDLE, gnt=0, done=0, abort=0, busy=0, cnt=0, tc=0, rr=0 (requester 0 preferred), prescaler=0.
REQ-027 Reset mid-RUN discards interval; no done/abort pulse on release; first grant evaluated the cycle after rst_n deasserts.

Configuration
REQ-028 Macro TIMER_SCHED_PRESCALE_EN defined: 4-bit free prescaler, counting in RUN only, cleared on entering RUN; tick when prescaler==15, i.e. one tick per 16 clk; RUN lasts 16*(tc+1) clk.
REQ-029 TIMER_SCHED_PRESCALE_EN undefined: no prescaler logic; tick=1 every RUN cycle.

Structure
REQ-030 Shared package timer_sched_pkg: state enum, NREQ constant, prescale width 4 and terminal value 15.
REQ-031 One sub-module sched_cnt: W-bit counter with clear, enable, terminal-compare output; FSM and arbiter stay in timer_sched.

Verification
REQ-032 Reset release, req=01, len0=5 -> gnt=01 cycle 1, cnt 0..5, done=01 at cycle 7, IDLE cycle 8.
REQ-033 req=11 from reset, len0=2, len1=3 -> req0 served first, then req1 granted 2 cycles after done[0]; done[1] pulse follows.
REQ-034 req0 served, req0 withdrawn at cnt=3 of len0=10 -> abort pulse, no done, cnt=0, next grant to req1 if pending.
REQ-035 len0=0 then len1=255 -> done after 1 tick; second interval cnt reaches 255 without wrap then done.
REQ-036 rst_n pulsed low at cnt=4 -> all outputs 0 immediately; no done/abort after release.
REQ-037 TIMER_SCHED_PRESCALE_EN build, len0=1 -> RUN 32 clk, cnt steps every 16 clk, done=01 once.
